// File: rtl/crc32_stream.sv
// ============================================================================
// crc32_stream : streaming reflected CRC-32 (0xEDB88320), DATA_W bits per beat
// Optional CRC32_STREAM_CHECK_EN adds match_o (FCS residue check). Rev 1.0
// ============================================================================
`default_nettype none

module crc32_stream #(
  parameter int          DATA_W = 32,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  valid_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [DATA_W/8-1:0]   keep_i,
  input  logic                  last_i,
  output logic                  ready_o,
  output logic [31:0]           crc_o,
  output logic                  crc_valid_o
`ifdef CRC32_STREAM_CHECK_EN
  ,
  output logic                  match_o
`endif
);

  localparam int          NB      = DATA_W / 8;
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_out_q;
  logic        finish;
  logic [NB:0][31:0] stage;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  // A new frame folds onto INIT even when a frame is already in progress.
  assign stage[0] = start_i ? INIT : crc_q;

  generate
    for (genvar b = 0; b < NB; b++) begin : g_byte
      assign stage[b+1] = (!last_i || keep_i[b]) ? crc_byte(stage[b], data_i[8*b +: 8])
                                                 : stage[b];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      crc_q     <= INIT;
      crc_out_q <= 32'h0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      if (finish) begin
        crc_out_q <= crc_d ^ XOROUT;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start_i || (state_q == S_RUN && valid_i)) begin
          crc_d   = valid_i ? stage[NB] : INIT;
          state_d = (valid_i && last_i) ? S_DONE : S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign finish = (state_d == S_DONE) && (state_q != S_DONE);

  always_comb begin
    ready_o     = !rst_i && (state_q != S_DONE);
    crc_valid_o = (state_q == S_DONE);
    crc_o       = crc_out_q;
  end

`ifdef CRC32_STREAM_CHECK_EN
  logic match_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      match_q <= 1'b0;
    end else if (finish) begin
      match_q <= (crc_d == RESIDUE);
    end
  end

  assign match_o = match_q;
`endif

endmodule

`default_nettype wire

// File: doc/crc32_stream.md
CRC32_STREAM -- requirements
Module: crc32_stream

Interface
REQ-001 Parameter DATA_W, default 32, meaning: beat width in bits; SHALL be one of 8, 16, 32 or 64.
REQ-002 Parameter INIT, default 32'hFFFFFFFF, meaning: CRC register preload on start.
REQ-003 Parameter XOROUT, default 32'hFFFFFFFF, meaning: final XOR applied to the result.
REQ-004 clk_i  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-005 rst_i  input  1  reset; synchronous and active-high.
REQ-006 start_i  input  1  begin a new frame: load INIT.
REQ-007 valid_i  input  1  data beat present.
REQ-008 data_i  input  DATA_W  beat data; byte 0 is data_i[7:0] and is processed first.
REQ-009 keep_i  input  DATA_W/8  byte enables; honoured on the last beat only.
REQ-010 last_i  input  1  qualifies the final beat of a frame.
REQ-011 ready_o  output  1  beat accepted when valid_i && ready_o.
REQ-012 crc_o  output  32  finished CRC, equal to register ^ XOROUT.
REQ-013 crc_valid_o  output  1  single-cycle pulse; crc_o is valid in that cycle.

Function
REQ-014 The block SHALL compute the reflected CRC-32 (poly 0xEDB88320), shifting right, with data LSB-first, per byte in ascending byte order.
REQ-015 The block SHALL fold a full DATA_W beat into the CRC register in one cycle; the combinational next-state SHALL be generated for the parametrised DATA_W.
REQ-016 States SHALL be IDLE, RUN and DONE.
- IDLE: start_i -> RUN.
- RUN: accepted beat with last_i -> DONE.
- DONE: unconditional -> IDLE after one cycle.
REQ-017 ready_o SHALL be 1 in IDLE and RUN, and 0 in DONE.
REQ-018 start_i SHALL load INIT into the register in the same cycle.
- If valid_i is also high in that cycle, the beat SHALL be folded into INIT, and last_i SHALL be honoured, giving a single-beat frame.
REQ-019 valid_i in IDLE without start_i SHALL be ignored; the register and outputs SHALL be unchanged.
REQ-020 start_i in RUN SHALL discard the partial frame and reload INIT; the concurrent-beat rule of REQ-018 SHALL apply.
REQ-021 On the last beat, only bytes with keep_i set SHALL be folded.
- keep_i SHALL be contiguous from bit 0.
- keep_i == 0 on the last beat SHALL fold no bytes.
- Non-contiguous keep_i is undefined, and the bench SHALL flag it as an assertion failure.
REQ-022 Latency: crc_valid_o SHALL pulse in DONE, one cycle after the last beat is accepted.
- crc_o SHALL update in that same cycle and hold until the next DONE.
REQ-023 Non-last beats SHALL fold all DATA_W/8 bytes regardless of keep_i.

Reset
REQ-024 While rst_i is high at a clock edge, the block SHALL apply the following on that edge:
- state SHALL go to IDLE.
- the CRC register SHALL load INIT.
- crc_o SHALL be 32'h0.
- crc_valid_o SHALL be 0.
- ready_o SHALL be 0 during the reset cycle and 1 from the first cycle after rst_i deasserts.
REQ-025 Reset mid-frame SHALL abandon the frame, and no crc_valid_o pulse SHALL be produced for it.

Configuration
REQ-026 Macro CRC32_STREAM_CHECK_EN defined: the block SHALL add output match_o (1 bit).
- match_o SHALL be valid with crc_valid_o.
- match_o SHALL be 1 when the pre-XOROUT register equals the CRC-32 residue 32'hDEBB20E3, i.e. the frame included its own FCS.
- match_o SHALL reset to 0.
REQ-027 Macro not defined: match_o and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 DATA_W=32. Beats: start_i with 32'h34333231; then 32'h38373635; then 32'h00000039 with last_i and keep_i=4'b0001 -> crc_o=32'hCBF43926 with crc_valid_o pulsing 1 cycle after the third beat.
REQ-029 DATA_W=8, ASCII "123456789" one byte per beat -> crc_o=32'hCBF43926; then a single-beat frame with start_i, valid_i and last_i together, byte 8'h00 -> crc_o=32'hD202EF8D.
REQ-030 DATA_W=64, frame "123456789" plus its FCS bytes 26 39 F4 CB, with CRC32_STREAM_CHECK_EN -> match_o=1; flip one data bit -> match_o=0.
REQ-031 Restart and protocol checks:
- start_i mid-frame after 2 beats of garbage, then "123456789" -> crc_o=32'hCBF43926.
- valid_i in IDLE without start_i -> no state change and no crc_valid_o pulse.
REQ-032 Reset and DONE-cycle checks:
- rst_i asserted for 1 cycle mid-frame -> no crc_valid_o pulse, crc_o=0, ready_o=1 on the next cycle.
- ready_o=0 for exactly one cycle in DONE, so a beat offered then is not accepted.
